// File: rtl/wager_ledger_pkg.sv
// Shared definitions for the wager ledger: default parameter values, ledger
// state constants, game state constants and the settled-result encoding.
// No ports.
package wager_ledger_pkg;

`include "ledgerState.svh"

  localparam int DEF_BANK_W      = 10;
  localparam int DEF_START_BANK  = 100;
  localparam int DEF_BANK_MAX    = 999;
  localparam int DEF_BET_MIN     = 5;
  localparam int DEF_BET_STEP    = 5;
  localparam int DEF_BET_DEFAULT = 10;
  localparam int DEF_STAT_W      = 8;

  localparam logic `ledgerState L_BETTING        = `L_BETTING;
  localparam logic `ledgerState L_IN_ROUND       = `L_IN_ROUND;
  localparam logic `ledgerState L_SETTLE         = `L_SETTLE;
  localparam logic `ledgerState L_WAIT_NEW_ROUND = `L_WAIT_NEW_ROUND;
  localparam logic `ledgerState L_BROKE          = `L_BROKE;

  localparam logic `gameState GS_RESET       = `S_RESET;
  localparam logic `gameState GS_DEAL_PLAYER = `S_DEAL_PLAYER;
  localparam logic `gameState GS_DEAL_DEALER = `S_DEAL_DEALER;
  localparam logic `gameState GS_PLAYER_TURN = `S_PLAYER_TURN;
  localparam logic `gameState GS_DEALER_TURN = `S_DEALER_TURN;
  localparam logic `gameState GS_RESULT_WIN  = `S_RESULT_WIN;
  localparam logic `gameState GS_RESULT_TIE  = `S_RESULT_TIE;
  localparam logic `gameState GS_RESULT_LOSE = `S_RESULT_LOSE;

  // Which statistics counter a settlement bumps.
  typedef enum logic [1:0] {
    RES_WIN  = 2'd0,
    RES_TIE  = 2'd1,
    RES_LOSE = 2'd2
  } resultKind_e;

endpackage

// File: rtl/gameState.svh
// Game FSM state encoding shared by the blackjack game FSM and its consumers.
// Provides the `gameState width macro and one macro per game state.
`ifndef GAMESTATE_SVH
`define GAMESTATE_SVH

`define gameState [3:0]

`define S_RESET        4'd0
`define S_DEAL_PLAYER  4'd1
`define S_DEAL_DEALER  4'd2
`define S_PLAYER_TURN  4'd3
`define S_DEALER_TURN  4'd4
`define S_RESULT_WIN   4'd5
`define S_RESULT_TIE   4'd6
`define S_RESULT_LOSE  4'd7

`endif

// File: rtl/ledgerState.svh
// Wager ledger state encoding, in the same macro style as gameState.svh.
// Provides the `ledgerState width macro, one macro per ledger state and the
// `isResultState(s) helper that recognises the three game result states.
`ifndef LEDGERSTATE_SVH
`define LEDGERSTATE_SVH

`include "gameState.svh"

`define ledgerState [2:0]

`define L_BETTING         3'd0
`define L_IN_ROUND        3'd1
`define L_SETTLE          3'd2
`define L_WAIT_NEW_ROUND  3'd3
`define L_BROKE           3'd4

`define isResultState(s) (((s) == `S_RESULT_WIN) || ((s) == `S_RESULT_TIE) || ((s) == `S_RESULT_LOSE))

`endif

// File: rtl/wager_ledger_bet_selector.sv
// bet_selector: holds the bet register for the wager ledger.
// Ports:
//   i_clk, i_reset  clock and asynchronous active-high reset (bet -> BET_DEFAULT)
//   enable          key presses are honoured only while high
//   betUp, betDown  one-cycle debounced key pulses; both at once means no change
//   bankroll        current bankroll, caps a raised bet and a low-bankroll bet
//   clampEn         high on the edge the ledger enters BETTING
//   clampBank       bankroll value the ledger holds after that edge
//   bet             registered bet
module bet_selector
  import wager_ledger_pkg::*;
#(
  parameter int BANK_W      = DEF_BANK_W,
  parameter int BET_MIN     = DEF_BET_MIN,
  parameter int BET_STEP    = DEF_BET_STEP,
  parameter int BET_DEFAULT = DEF_BET_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              enable,
  input  logic              betUp,
  input  logic              betDown,
  input  logic [BANK_W-1:0] bankroll,
  input  logic              clampEn,
  input  logic [BANK_W-1:0] clampBank,
  output logic [BANK_W-1:0] bet
);

  localparam logic [BANK_W-1:0] MIN_V  = BANK_W'(BET_MIN);
  localparam logic [BANK_W-1:0] STEP_V = BANK_W'(BET_STEP);
  localparam logic [BANK_W-1:0] DEF_V  = BANK_W'(BET_DEFAULT);

  logic [BANK_W-1:0] bet_r;
  logic [BANK_W-1:0] adjusted_s;
  logic [BANK_W-1:0] lowClamped_s;
  logic [BANK_W-1:0] betNext_s;
  logic [BANK_W:0]   raised_s;

  // Next bet: one-direction key step, then low-bankroll clamp, then entry clamp.
  always_comb begin
    // One spare bit so a raise near the top of the range cannot wrap.
    raised_s     = {1'b0, bet_r} + {1'b0, STEP_V};
    adjusted_s   = bet_r;
    lowClamped_s = bet_r;
    betNext_s    = bet_r;
    if (enable && betUp && !betDown) begin
      if (raised_s > {1'b0, bankroll}) begin
        adjusted_s = bankroll;
      end else begin
        adjusted_s = raised_s[BANK_W-1:0];
      end
    end else if (enable && betDown && !betUp) begin
      // Compare before subtracting so a bet below MIN+STEP never underflows.
      if (bet_r >= (MIN_V + STEP_V)) begin
        adjusted_s = bet_r - STEP_V;
      end else begin
        adjusted_s = MIN_V;
      end
    end else begin
      adjusted_s = bet_r;
    end

    if (enable && (bankroll < MIN_V) && (adjusted_s > bankroll)) begin
      lowClamped_s = bankroll;
    end else begin
      lowClamped_s = adjusted_s;
    end

    if (clampEn && (lowClamped_s > clampBank)) begin
      betNext_s = clampBank;
    end else begin
      betNext_s = lowClamped_s;
    end
  end

  // Bet register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bet_r <= DEF_V;
    end else begin
      bet_r <= betNext_s;
    end
  end

  assign bet = bet_r;

endmodule

// File: rtl/wager_ledger.sv
// wager_ledger: bankroll and bet bookkeeping downstream of the blackjack game FSM.
// Ports:
//   i_clk, i_reset      clock and asynchronous active-high reset (clears all state)
//   i_gameState         current game FSM state
//   i_playerBlackjack   player holds a 2-card 21, sampled with a WIN result
//   i_betUp, i_betDown  debounced one-cycle bet key pulses
//   o_bankroll          current bankroll
//   o_bet               next-round bet, or the active bet while a round runs
//   o_lastPayout        amount credited by the most recent settlement
//   o_settleValid       one-cycle pulse when the settled bankroll first shows
//   o_wins/o_losses/o_ties  saturating round statistics
//   o_betLocked         high in IN_ROUND and SETTLE
//   o_broke             high in BROKE
`include "ledgerState.svh"

module wager_ledger
  import wager_ledger_pkg::*;
#(
  parameter int BANK_W      = DEF_BANK_W,
  parameter int START_BANK  = DEF_START_BANK,
  parameter int BANK_MAX    = DEF_BANK_MAX,
  parameter int BET_MIN     = DEF_BET_MIN,
  parameter int BET_STEP    = DEF_BET_STEP,
  parameter int BET_DEFAULT = DEF_BET_DEFAULT,
  parameter int STAT_W      = DEF_STAT_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic `gameState   i_gameState,
  input  logic              i_playerBlackjack,
  input  logic              i_betUp,
  input  logic              i_betDown,
  output logic [BANK_W-1:0] o_bankroll,
  output logic [BANK_W-1:0] o_bet,
  output logic [BANK_W+1:0] o_lastPayout,
  output logic              o_settleValid,
  output logic [STAT_W-1:0] o_wins,
  output logic [STAT_W-1:0] o_losses,
  output logic [STAT_W-1:0] o_ties,
  output logic              o_betLocked,
  output logic              o_broke
);

  localparam int PAY_W = BANK_W + 2;
  localparam logic [BANK_W-1:0] START_V = BANK_W'(START_BANK);
  localparam logic [BANK_W-1:0] MAX_V   = BANK_W'(BANK_MAX);
  localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};
  localparam logic [STAT_W-1:0] STAT_TOP = {STAT_W{1'b1}};

  // Saturating increment for the statistics counters.
  function automatic logic [STAT_W-1:0] satInc(input logic [STAT_W-1:0] v);
    if (v == STAT_TOP) begin
      return v;
    end else begin
      return v + STAT_ONE;
    end
  endfunction

  logic `ledgerState state_r, stateNext_s;
  logic [BANK_W-1:0] bankroll_r, bankrollNext_s;
  logic [BANK_W-1:0] activeBet_r, activeBetNext_s;
  logic [PAY_W-1:0]  lastPayout_r, lastPayoutNext_s;
  resultKind_e       resultKind_r, resultKindNext_s;
  logic [STAT_W-1:0] wins_r, winsNext_s;
  logic [STAT_W-1:0] losses_r, lossesNext_s;
  logic [STAT_W-1:0] ties_r, tiesNext_s;
  logic              settleValid_r;
  logic              betLocked_r;
  logic              broke_r;

  logic [BANK_W-1:0] bet_s;
  logic              betEnable_s;
  logic              enterBetting_s;
  logic [PAY_W-1:0]  payout_s;
  logic [PAY_W-1:0]  settleSum_s;
  logic [BANK_W-1:0] settledBank_s;

  // Bet keys are live while choosing a bet, but not on the deal edge itself,
  // so the bet latched into the round is the one shown on o_bet.
  assign betEnable_s = ((state_r == L_BETTING) && (i_gameState != GS_DEAL_DEALER))
                    || (state_r == L_WAIT_NEW_ROUND);
  assign enterBetting_s = (stateNext_s == L_BETTING) && (state_r != L_BETTING);

  bet_selector #(
    .BANK_W      (BANK_W),
    .BET_MIN     (BET_MIN),
    .BET_STEP    (BET_STEP),
    .BET_DEFAULT (BET_DEFAULT)
  ) u_betSelector (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .enable    (betEnable_s),
    .betUp     (i_betUp),
    .betDown   (i_betDown),
    .bankroll  (bankroll_r),
    .clampEn   (enterBetting_s),
    .clampBank (bankrollNext_s),
    .bet       (bet_s)
  );

  // Payout for the result currently presented, and the saturated settle sum.
  always_comb begin
    payout_s = {PAY_W{1'b0}};
    if (i_gameState == GS_RESULT_WIN) begin
      if (i_playerBlackjack) begin
        payout_s = {1'b0, activeBet_r, 1'b0} + {3'b000, activeBet_r[BANK_W-1:1]};
      end else begin
        payout_s = {1'b0, activeBet_r, 1'b0};
      end
    end else if (i_gameState == GS_RESULT_TIE) begin
      payout_s = {2'b00, activeBet_r};
    end else begin
      payout_s = {PAY_W{1'b0}};
    end

    settleSum_s = {2'b00, bankroll_r} + lastPayout_r;
    if (settleSum_s > {2'b00, MAX_V}) begin
      settledBank_s = MAX_V;
    end else begin
      settledBank_s = settleSum_s[BANK_W-1:0];
    end
  end

  // Ledger FSM and bankroll/statistics next-state logic.
  always_comb begin
    stateNext_s      = state_r;
    bankrollNext_s   = bankroll_r;
    activeBetNext_s  = activeBet_r;
    lastPayoutNext_s = lastPayout_r;
    resultKindNext_s = resultKind_r;
    winsNext_s       = wins_r;
    lossesNext_s     = losses_r;
    tiesNext_s       = ties_r;
    case (state_r)
      L_BETTING: begin
        if (i_gameState == GS_DEAL_DEALER) begin
          stateNext_s     = L_IN_ROUND;
          activeBetNext_s = bet_s;
          bankrollNext_s  = bankroll_r - bet_s;
        end else begin
          stateNext_s = L_BETTING;
        end
      end
      L_IN_ROUND: begin
        if (`isResultState(i_gameState)) begin
          stateNext_s      = L_SETTLE;
          lastPayoutNext_s = payout_s;
          if (i_gameState == GS_RESULT_WIN) begin
            resultKindNext_s = RES_WIN;
          end else if (i_gameState == GS_RESULT_TIE) begin
            resultKindNext_s = RES_TIE;
          end else begin
            resultKindNext_s = RES_LOSE;
          end
        end else if (i_gameState == GS_RESET) begin
          // Void round: the stake goes back untouched.
          stateNext_s    = L_BETTING;
          bankrollNext_s = bankroll_r + activeBet_r;
        end else begin
          stateNext_s = L_IN_ROUND;
        end
      end
      L_SETTLE: begin
        bankrollNext_s = settledBank_s;
        case (resultKind_r)
          RES_WIN:  winsNext_s   = satInc(wins_r);
          RES_TIE:  tiesNext_s   = satInc(ties_r);
          RES_LOSE: lossesNext_s = satInc(losses_r);
          default:  winsNext_s   = wins_r;
        endcase
        if (settledBank_s == {BANK_W{1'b0}}) begin
          stateNext_s = L_BROKE;
        end else begin
          stateNext_s = L_WAIT_NEW_ROUND;
        end
      end
      L_WAIT_NEW_ROUND: begin
        // A result state that lingers here is ignored; only S_RESET moves on.
        if (i_gameState == GS_RESET) begin
          stateNext_s = L_BETTING;
        end else begin
          stateNext_s = L_WAIT_NEW_ROUND;
        end
      end
      L_BROKE: begin
        stateNext_s = L_BROKE;
      end
      default: begin
        stateNext_s = L_BETTING;
      end
    endcase
  end

  // State, bankroll, statistics and registered status outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r       <= L_BETTING;
      bankroll_r    <= START_V;
      activeBet_r   <= {BANK_W{1'b0}};
      lastPayout_r  <= {PAY_W{1'b0}};
      resultKind_r  <= RES_WIN;
      wins_r        <= {STAT_W{1'b0}};
      losses_r      <= {STAT_W{1'b0}};
      ties_r        <= {STAT_W{1'b0}};
      settleValid_r <= 1'b0;
      betLocked_r   <= 1'b0;
      broke_r       <= 1'b0;
    end else begin
      state_r       <= stateNext_s;
      bankroll_r    <= bankrollNext_s;
      activeBet_r   <= activeBetNext_s;
      lastPayout_r  <= lastPayoutNext_s;
      resultKind_r  <= resultKindNext_s;
      wins_r        <= winsNext_s;
      losses_r      <= lossesNext_s;
      ties_r        <= tiesNext_s;
      settleValid_r <= (state_r == L_SETTLE);
      betLocked_r   <= (stateNext_s == L_IN_ROUND) || (stateNext_s == L_SETTLE);
      broke_r       <= (stateNext_s == L_BROKE);
    end
  end

  assign o_bankroll    = bankroll_r;
  assign o_bet         = bet_s;
  assign o_lastPayout  = lastPayout_r;
  assign o_settleValid = settleValid_r;
  assign o_wins        = wins_r;
  assign o_losses      = losses_r;
  assign o_ties        = ties_r;
  assign o_betLocked   = betLocked_r;
  assign o_broke       = broke_r;

endmodule

// File: tb/tb_wager_ledger.sv
// Self-checking bench for wager_ledger. Stimulus pushes the expected settlement
// record into a queue; a monitor pops and compares on every o_settleValid.
module tb_wager_ledger;
  import wager_ledger_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [3:0]  i_gameState = 4'd0;
  logic        i_playerBlackjack = 1'b0;
  logic        i_betUp = 1'b0;
  logic        i_betDown = 1'b0;
  logic [9:0]  o_bankroll;
  logic [9:0]  o_bet;
  logic [11:0] o_lastPayout;
  logic        o_settleValid;
  logic [7:0]  o_wins;
  logic [7:0]  o_losses;
  logic [7:0]  o_ties;
  logic        o_betLocked;
  logic        o_broke;

  typedef struct {
    int bank;
    int pay;
    int w;
    int l;
    int t;
  } exp_t;

  exp_t sbQ[$];
  int total = 0;
  int bad = 0;
  int settleSeen = 0;
  int settleExpected = 0;

  wager_ledger dut (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_gameState       (i_gameState),
    .i_playerBlackjack (i_playerBlackjack),
    .i_betUp           (i_betUp),
    .i_betDown         (i_betDown),
    .o_bankroll        (o_bankroll),
    .o_bet             (o_bet),
    .o_lastPayout      (o_lastPayout),
    .o_settleValid     (o_settleValid),
    .o_wins            (o_wins),
    .o_losses          (o_losses),
    .o_ties            (o_ties),
    .o_betLocked       (o_betLocked),
    .o_broke           (o_broke)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every settle pulse must match the oldest expectation.
  always @(negedge i_clk) begin
    if (o_settleValid === 1'b1) begin
      settleSeen++;
      if (sbQ.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_settle: got pulse expected none (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        check("settle_bankroll", int'(o_bankroll), e.bank);
        check("settle_payout", int'(o_lastPayout), e.pay);
        check("settle_wins", int'(o_wins), e.w);
        check("settle_losses", int'(o_losses), e.l);
        check("settle_ties", int'(o_ties), e.t);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] s);
    i_gameState = s;
    tick();
  endtask

  task automatic doReset();
    i_reset = 1'b1;
    i_gameState = GS_RESET;
    tick();
    i_reset = 1'b0;
    tick();
  endtask

  task automatic pulseUp(input int n);
    for (int i = 0; i < n; i++) begin
      i_betUp = 1'b1;
      tick();
      i_betUp = 1'b0;
      tick();
    end
  endtask

  task automatic pulseDown(input int n);
    for (int i = 0; i < n; i++) begin
      i_betDown = 1'b1;
      tick();
      i_betDown = 1'b0;
      tick();
    end
  endtask

  task automatic playRound(input logic [3:0] res, input logic bj, input int holdN,
                           input int dealBank, input exp_t e);
    drive(GS_RESET);
    drive(GS_DEAL_PLAYER);
    drive(GS_DEAL_DEALER);
    check("deal_bankroll", int'(o_bankroll), dealBank);
    check("deal_locked", int'(o_betLocked), 1);
    drive(GS_PLAYER_TURN);
    drive(GS_DEALER_TURN);
    sbQ.push_back(e);
    settleExpected++;
    i_playerBlackjack = bj;
    for (int i = 0; i < holdN; i++) begin
      drive(res);
    end
    i_playerBlackjack = 1'b0;
    drive(GS_RESET);
  endtask

  initial begin
    // Reset values.
    doReset();
    check("rst_bankroll", int'(o_bankroll), 100);
    check("rst_bet", int'(o_bet), 10);
    check("rst_payout", int'(o_lastPayout), 0);
    check("rst_settle", int'(o_settleValid), 0);
    check("rst_wins", int'(o_wins), 0);
    check("rst_losses", int'(o_losses), 0);
    check("rst_ties", int'(o_ties), 0);
    check("rst_locked", int'(o_betLocked), 0);
    check("rst_broke", int'(o_broke), 0);

    // Plain win with the default bet of 10.
    playRound(GS_RESULT_WIN, 1'b0, 4, 90, '{110, 20, 1, 0, 0});
    check("win_unlocked", int'(o_betLocked), 0);

    // Blackjack win with bet 15: payout 30 + 7.
    doReset();
    pulseUp(1);
    check("bj_bet", int'(o_bet), 15);
    playRound(GS_RESULT_WIN, 1'b1, 4, 85, '{122, 37, 1, 0, 0});

    // Tie then loss, each result held 20 cycles.
    doReset();
    playRound(GS_RESULT_TIE, 1'b0, 20, 90, '{100, 10, 0, 0, 1});
    playRound(GS_RESULT_LOSE, 1'b0, 20, 90, '{90, 0, 0, 1, 1});

    // All-in loss goes broke; keys and deals are then ignored.
    doReset();
    pulseUp(20);
    check("allin_bet", int'(o_bet), 100);
    playRound(GS_RESULT_LOSE, 1'b0, 4, 0, '{0, 0, 0, 1, 0});
    check("broke_flag", int'(o_broke), 1);
    check("broke_bankroll", int'(o_bankroll), 0);
    pulseUp(3);
    check("broke_bet_frozen", int'(o_bet), 100);
    drive(GS_DEAL_DEALER);
    check("broke_deal_bankroll", int'(o_bankroll), 0);
    check("broke_deal_locked", int'(o_betLocked), 0);
    drive(GS_RESET);

    // Climb to 990, then a bet-10 win saturates at 999.
    doReset();
    pulseUp(18);
    check("sat_bet100", int'(o_bet), 100);
    playRound(GS_RESULT_WIN, 1'b1, 4, 0, '{250, 250, 1, 0, 0});
    pulseUp(30);
    check("sat_bet250", int'(o_bet), 250);
    playRound(GS_RESULT_WIN, 1'b1, 4, 0, '{625, 625, 2, 0, 0});
    pulseUp(23);
    check("sat_bet365", int'(o_bet), 365);
    playRound(GS_RESULT_WIN, 1'b0, 4, 260, '{990, 730, 3, 0, 0});
    pulseDown(71);
    check("sat_bet10", int'(o_bet), 10);
    playRound(GS_RESULT_WIN, 1'b0, 4, 980, '{999, 20, 4, 0, 0});
    check("sat_final", int'(o_bankroll), 999);

    // Void round refunds the stake with no statistics change.
    doReset();
    drive(GS_RESET);
    drive(GS_DEAL_PLAYER);
    drive(GS_DEAL_DEALER);
    check("void_deal", int'(o_bankroll), 90);
    drive(GS_PLAYER_TURN);
    drive(GS_RESET);
    check("void_refund", int'(o_bankroll), 100);
    check("void_wins", int'(o_wins), 0);
    check("void_losses", int'(o_losses), 0);
    check("void_ties", int'(o_ties), 0);
    check("void_unlocked", int'(o_betLocked), 0);

    // Reset while in SETTLE: no settlement, everything back to reset values.
    playRound(GS_RESULT_WIN, 1'b0, 4, 90, '{110, 20, 1, 0, 0});
    pulseUp(1);
    check("rs_bet15", int'(o_bet), 15);
    drive(GS_RESET);
    drive(GS_DEAL_PLAYER);
    drive(GS_DEAL_DEALER);
    check("rs_deal", int'(o_bankroll), 95);
    drive(GS_PLAYER_TURN);
    drive(GS_RESULT_WIN);
    i_reset = 1'b1;
    #1;
    check("rs_bankroll", int'(o_bankroll), 100);
    check("rs_wins", int'(o_wins), 0);
    check("rs_payout", int'(o_lastPayout), 0);
    check("rs_bet", int'(o_bet), 10);
    check("rs_locked", int'(o_betLocked), 0);
    i_gameState = GS_RESET;
    tick();
    i_reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
    end
    check("rs_after_bankroll", int'(o_bankroll), 100);
    check("rs_after_wins", int'(o_wins), 0);

    // Every expected settlement arrived, and no others.
    tick();
    tick();
    check("sb_drained", sbQ.size(), 0);
    check("settle_count", settleSeen, settleExpected);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
